// File: rtl/cache_control_if.sv
// cache_control_if: CPU, datapath and cacheline-adaptor signals seen by the cache controller
interface cache_control_if;
  logic       mem_read, mem_write, mem_resp;
  logic       pmem_read, pmem_write, pmem_resp;
  logic       HIT, way_hit, lru_data;
  logic [1:0] valid_out, dirty_out;
  logic [1:0] LD_DIRTY, LD_VALID, LD_TAG;
  logic       dirty_in, valid_in, LD_LRU, lru_in;
  logic [2:0] W_CACHE_STATUS;
  modport master (
    input  mem_read, mem_write, pmem_resp, HIT, way_hit, lru_data, valid_out, dirty_out,
    output mem_resp, pmem_read, pmem_write, LD_DIRTY, LD_VALID, LD_TAG,
           dirty_in, valid_in, LD_LRU, lru_in, W_CACHE_STATUS
  );
  modport slave (
    output mem_read, mem_write, pmem_resp, HIT, way_hit, lru_data, valid_out, dirty_out,
    input  mem_resp, pmem_read, pmem_write, LD_DIRTY, LD_VALID, LD_TAG,
           dirty_in, valid_in, LD_LRU, lru_in, W_CACHE_STATUS
  );
endinterface

// File: rtl/cache_control.sv
// cache_control: 2-way write-back cache sequencer; CACHE_PERF_CNT_EN adds hit/miss/writeback counters
module cache_control
`ifdef CACHE_PERF_CNT_EN
  #(parameter int CNT_WIDTH = 32)
`endif
(
  input  logic clk,
  input  logic rst,
  cache_control_if.master bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
  state_t state;
  logic from_fill;
  logic chk, wb, fl, hit, wr_hit, wb_done, fill_done;
  logic [1:0] victim, hit_way;
  assign chk       = !rst && state == CHECK;
  assign wb        = !rst && state == WRITEBACK;
  assign fl        = !rst && state == FILL;
  assign hit       = chk && bus.HIT;
  assign wr_hit    = hit && bus.mem_write;
  assign wb_done   = wb && bus.pmem_resp;
  assign fill_done = fl && bus.pmem_resp;
  assign victim    = bus.lru_data ? 2'b10 : 2'b01;
  assign hit_way   = bus.way_hit ? 2'b10 : 2'b01;
  // state sequencing; from_fill marks a CHECK that re-checks a freshly filled line
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      from_fill <= 1'b0;
    end else begin
      from_fill <= state == FILL;
      case (state)
        IDLE:      if (bus.mem_read || bus.mem_write) state <= CHECK;
        CHECK:     state <= bus.HIT ? IDLE : bus.dirty_out[bus.lru_data] ? WRITEBACK : FILL;
        WRITEBACK: if (bus.pmem_resp) state <= FILL;
        FILL:      if (bus.pmem_resp) state <= CHECK;
        default:   state <= IDLE;
      endcase
    end
  // datapath strobes and handshakes, all forced low during reset
  always_comb begin
    bus.mem_resp       = hit;
    bus.LD_LRU         = hit;
    bus.lru_in         = hit && !bus.way_hit;
    bus.pmem_write     = wb;
    bus.pmem_read      = fl;
    bus.LD_DIRTY       = wr_hit ? hit_way : (wb_done || fill_done) ? victim : 2'b00;
    bus.dirty_in       = wr_hit;
    bus.LD_TAG         = fill_done ? victim : 2'b00;
    bus.LD_VALID       = fill_done ? victim : 2'b00;
    bus.valid_in       = fill_done;
    bus.W_CACHE_STATUS = wr_hit ? 3'b100 : fill_done ? 3'b011 : ((chk && !bus.HIT) || wb || fl) ? 3'b001 : 3'b000;
  end
`ifdef CACHE_PERF_CNT_EN
  // event counters, wrapping naturally at CNT_WIDTH
  always_ff @(posedge clk)
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit && !from_fill) hit_count <= hit_count + 1'b1;
      if (chk && !bus.HIT) miss_count <= miss_count + 1'b1;
      if (wb_done) wb_count <= wb_count + 1'b1;
    end
`endif
endmodule
